// File: rtl/dmem_arb_pkg.sv
// ============================================================================
// Module : dmem_arb_pkg
// Brief  : Shared types and constants for the data-memory port arbiter.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dmem_arb_pkg;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_e;

    typedef enum logic [0:0] {
        REQ_LSU = 1'b0,
        REQ_EXT = 1'b1
    } req_id_e;

    function automatic int unsigned stride_bytes(input int unsigned data_w);
        return data_w / 8;
    endfunction

    localparam int unsigned STRIDE = stride_bytes(64);

endpackage

`default_nettype wire

// File: rtl/dmem_arbiter_rr_arb2.sv
// ============================================================================
// Module : rr_arb2
// Brief  : Two-input round-robin picker; owns the "last granted" flop.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arb2
    import dmem_arb_pkg::*;
(
    input  logic clk,
    input  logic arst_n,
    input  logic i_en,
    input  logic i_req_lsu,
    input  logic i_req_ext,
    input  logic i_hold_ext,
    output logic o_gnt_lsu,
    output logic o_gnt_ext
);

    req_id_e r_last;

    always_comb begin
        o_gnt_lsu = 1'b0;
        o_gnt_ext = 1'b0;
        if (i_en) begin
            if (i_req_lsu && i_req_ext) begin
                o_gnt_lsu = (r_last == REQ_EXT);
                o_gnt_ext = (r_last == REQ_LSU);
            end else begin
                o_gnt_lsu = i_req_lsu;
                o_gnt_ext = i_req_ext;
            end
        end
    end

    // Burst beats count as external grants so the LSU wins right after a burst.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_last <= REQ_EXT;
        end else if (o_gnt_lsu) begin
            r_last <= REQ_LSU;
        end else if (o_gnt_ext || i_hold_ext) begin
            r_last <= REQ_EXT;
        end
    end

endmodule

`default_nettype wire

// File: rtl/dmem_arbiter.sv
// ============================================================================
// Module : dmem_arbiter
// Brief  : Shares one SRAM port between the LSU and the external burst master.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64,
    parameter int LEN_W  = 4
) (
    input  logic              clk,
    input  logic              arst_n,
    input  logic              lsu_req,
    input  logic              lsu_wen,
    input  logic [ADDR_W-1:0] lsu_addr,
    input  logic [DATA_W-1:0] lsu_wdata,
    output logic              lsu_gnt,
    output logic              lsu_rvalid,
    output logic [DATA_W-1:0] lsu_rdata,
    input  logic              ext_req,
    input  logic              ext_wen,
    input  logic [ADDR_W-1:0] ext_addr,
    input  logic [DATA_W-1:0] ext_wdata,
    input  logic [LEN_W-1:0]  ext_len,
    output logic              ext_gnt,
    output logic              ext_rvalid,
    output logic [DATA_W-1:0] ext_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wen,
    output logic              mem_ren,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam logic [ADDR_W-1:0] c_STRIDE = ADDR_W'(stride_bytes(DATA_W));

    state_e            r_state;
    logic [LEN_W-1:0]  r_beat_cnt;
    logic [ADDR_W-1:0] r_burst_addr;
    logic              r_burst_wen;
    logic              r_rd_valid;
    req_id_e           r_rd_id;

    logic w_idle;
    logic w_arb_lsu;
    logic w_arb_ext;
    logic w_burst_beat;

    assign w_idle       = (r_state == ST_IDLE);
    assign w_burst_beat = !w_idle && ext_req && arst_n;

    rr_arb2 u_rr_arb2 (
        .clk        (clk),
        .arst_n     (arst_n),
        .i_en       (w_idle && arst_n),
        .i_req_lsu  (lsu_req),
        .i_req_ext  (ext_req),
        .i_hold_ext (w_burst_beat),
        .o_gnt_lsu  (w_arb_lsu),
        .o_gnt_ext  (w_arb_ext)
    );

    assign lsu_gnt = w_arb_lsu;
    assign ext_gnt = w_arb_ext || w_burst_beat;
    assign busy    = (r_state == ST_BURST);

    always_comb begin
        mem_addr  = '0;
        mem_wen   = 1'b0;
        mem_ren   = 1'b0;
        mem_wdata = '0;
        if (w_arb_lsu) begin
            mem_addr  = lsu_addr;
            mem_wen   = lsu_wen;
            mem_ren   = !lsu_wen;
            mem_wdata = lsu_wdata;
        end else if (w_arb_ext) begin
            mem_addr  = ext_addr;
            mem_wen   = ext_wen;
            mem_ren   = !ext_wen;
            mem_wdata = ext_wdata;
        end else if (w_burst_beat) begin
            mem_addr  = r_burst_addr;
            mem_wen   = r_burst_wen;
            mem_ren   = !r_burst_wen;
            mem_wdata = ext_wdata;
        end
    end

    assign lsu_rvalid = r_rd_valid && (r_rd_id == REQ_LSU);
    assign ext_rvalid = r_rd_valid && (r_rd_id == REQ_EXT);
    assign lsu_rdata  = lsu_rvalid ? mem_rdata : '0;
    assign ext_rdata  = ext_rvalid ? mem_rdata : '0;

    // A dropped ext_req inside a burst aborts it; the arbiter sees IDLE next cycle.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_state      <= ST_IDLE;
            r_beat_cnt   <= '0;
            r_burst_addr <= '0;
            r_burst_wen  <= 1'b0;
            r_rd_valid   <= 1'b0;
            r_rd_id      <= REQ_LSU;
        end else begin
            r_rd_valid <= mem_ren;
            if (mem_ren) begin
                r_rd_id <= w_arb_lsu ? REQ_LSU : REQ_EXT;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_arb_ext && (ext_len != '0)) begin
                        r_state      <= ST_BURST;
                        r_beat_cnt   <= ext_len;
                        r_burst_addr <= ext_addr + c_STRIDE;
                        r_burst_wen  <= ext_wen;
                    end
                end
                ST_BURST: begin
                    if (!ext_req) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_burst_addr <= r_burst_addr + c_STRIDE;
                        r_beat_cnt   <= r_beat_cnt - LEN_W'(1);
                        if (r_beat_cnt == LEN_W'(1)) begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
// ============================================================================
// Module : tb_dmem_arbiter
// Brief  : Directed and random checks of dmem_arbiter against a cycle model.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dmem_arbiter;

    logic        clk;
    logic        arst_n;
    logic        lsu_req, lsu_wen, lsu_gnt, lsu_rvalid;
    logic [63:0] lsu_addr, lsu_wdata, lsu_rdata;
    logic        ext_req, ext_wen, ext_gnt, ext_rvalid;
    logic [63:0] ext_addr, ext_wdata, ext_rdata;
    logic [3:0]  ext_len;
    logic [63:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_wen, mem_ren, busy;

    int n_checks = 0;
    int n_fail   = 0;

    dmem_arbiter #(.ADDR_W(64), .DATA_W(64), .LEN_W(4)) dut (
        .clk        (clk),
        .arst_n     (arst_n),
        .lsu_req    (lsu_req),
        .lsu_wen    (lsu_wen),
        .lsu_addr   (lsu_addr),
        .lsu_wdata  (lsu_wdata),
        .lsu_gnt    (lsu_gnt),
        .lsu_rvalid (lsu_rvalid),
        .lsu_rdata  (lsu_rdata),
        .ext_req    (ext_req),
        .ext_wen    (ext_wen),
        .ext_addr   (ext_addr),
        .ext_wdata  (ext_wdata),
        .ext_len    (ext_len),
        .ext_gnt    (ext_gnt),
        .ext_rvalid (ext_rvalid),
        .ext_rdata  (ext_rdata),
        .mem_addr   (mem_addr),
        .mem_wen    (mem_wen),
        .mem_ren    (mem_ren),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM stand-in: 256 words indexed by addr[10:3], one-cycle read latency.
    logic [63:0] sram    [256];
    logic [63:0] ref_mem [256];

    function automatic logic [63:0] pattern(input int i);
        return {32'(i) * 32'h9E37_79B9, ~32'(i)};
    endfunction

    always @(posedge clk) begin
        if (mem_wen) sram[mem_addr[10:3]] <= mem_wdata;
        if (mem_ren) mem_rdata <= sram[mem_addr[10:3]];
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    // Reference model: burst tracked as base address plus beat index.
    bit          m_burst;
    int          m_last;
    logic [63:0] m_base;
    int          m_idx, m_total;
    bit          m_bwen;
    bit          m_pend_v;
    int          m_pend_id;
    logic [63:0] m_pend_data;
    bit          e_lg, e_eg, e_wen, e_ren;
    logic [63:0] e_addr, e_wdata;

    task automatic model_reset();
        m_burst  = 0;
        m_last   = 1;
        m_pend_v = 0;
    endtask

    task automatic eval_check();
        e_lg = 0; e_eg = 0; e_wen = 0; e_addr = '0; e_wdata = '0;
        if (!m_burst) begin
            if (lsu_req && ext_req) e_lg = (m_last == 1);
            else                    e_lg = lsu_req;
            e_eg = ext_req && !e_lg;
        end else begin
            e_eg = ext_req;
        end
        if (e_lg) begin
            e_addr = lsu_addr; e_wen = lsu_wen; e_wdata = lsu_wdata;
        end else if (e_eg) begin
            e_addr  = m_burst ? m_base + 64'(m_idx) * 64'd8 : ext_addr;
            e_wen   = m_burst ? m_bwen : ext_wen;
            e_wdata = ext_wdata;
        end
        e_ren = (e_lg || e_eg) && !e_wen;
        chk("lsu_gnt", 64'(lsu_gnt), 64'(e_lg));
        chk("ext_gnt", 64'(ext_gnt), 64'(e_eg));
        chk("mem_wen", 64'(mem_wen), 64'(e_wen));
        chk("mem_ren", 64'(mem_ren), 64'(e_ren));
        if (e_lg || e_eg) chk("mem_addr", mem_addr, e_addr);
        if (e_wen) chk("mem_wdata", mem_wdata, e_wdata);
        chk("busy", 64'(busy), 64'(m_burst));
        chk("lsu_rvalid", 64'(lsu_rvalid), 64'(m_pend_v && m_pend_id == 0));
        chk("ext_rvalid", 64'(ext_rvalid), 64'(m_pend_v && m_pend_id == 1));
        if (m_pend_v) begin
            chk("lsu_rdata", lsu_rdata, (m_pend_id == 0) ? m_pend_data : 64'd0);
            chk("ext_rdata", ext_rdata, (m_pend_id == 1) ? m_pend_data : 64'd0);
        end
    endtask

    task automatic model_update();
        m_pend_v = e_ren;
        if (e_ren) begin
            m_pend_id   = e_lg ? 0 : 1;
            m_pend_data = ref_mem[e_addr[10:3]];
        end
        if (e_wen) ref_mem[e_addr[10:3]] = e_wdata;
        if (e_lg)      m_last = 0;
        else if (e_eg) m_last = 1;
        if (!m_burst) begin
            if (e_eg && ext_len != 4'd0) begin
                m_burst = 1; m_base = ext_addr; m_idx = 1;
                m_total = int'(ext_len) + 1; m_bwen = ext_wen;
            end
        end else if (!ext_req) begin
            m_burst = 0;
        end else begin
            m_idx++;
            if (m_idx == m_total) m_burst = 0;
        end
    endtask

    task automatic step();
        #1;
        eval_check();
        model_update();
        @(negedge clk);
    endtask

    task automatic drive(input bit lr, input bit lw, input logic [63:0] la,
                         input bit er, input bit ew, input logic [63:0] ea,
                         input logic [3:0] el);
        lsu_req = lr; lsu_wen = lw; lsu_addr = la; lsu_wdata = {$urandom, $urandom};
        ext_req = er; ext_wen = ew; ext_addr = ea; ext_wdata = {$urandom, $urandom};
        ext_len = el;
    endtask

    task automatic hard_reset();
        arst_n = 1'b0;
        drive(1, 0, 64'h40, 1, 1, 64'h48, 4'd2);
        #1;
        chk("rst_lsu_gnt", 64'(lsu_gnt), 64'd0);
        chk("rst_ext_gnt", 64'(ext_gnt), 64'd0);
        chk("rst_mem_en", 64'({mem_wen, mem_ren}), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_rvalid", 64'({lsu_rvalid, ext_rvalid}), 64'd0);
        @(negedge clk);
        @(negedge clk);
        arst_n = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0);
        model_reset();
    endtask

    function automatic logic [63:0] rand_addr();
        if ($urandom_range(0, 15) == 0) return 64'hFFFF_FFFF_FFFF_FFE0 + 64'({$urandom_range(0, 3), 3'b000});
        return 64'({$urandom_range(0, 63), 3'b000});
    endfunction

    initial begin
        for (int i = 0; i < 256; i++) begin
            sram[i]    <= pattern(i);
            ref_mem[i]  = pattern(i);
        end
        arst_n = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0);
        #2;
        hard_reset();

        // Single LSU read of 0x10
        drive(1, 0, 64'h10, 0, 0, 0, 0);
        #1;
        chk("t1_gnt", 64'(lsu_gnt), 64'd1);
        chk("t1_addr", mem_addr, 64'h10);
        step();
        drive(0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("t1_rvalid", 64'(lsu_rvalid), 64'd1);
        chk("t1_rdata", lsu_rdata, pattern(2));
        step();

        // Continuous contention alternates starting with the LSU
        hard_reset();
        for (int i = 0; i < 6; i++) begin
            drive(1, 0, rand_addr(), 1, 0, rand_addr(), 0);
            #1;
            chk("t2_alt", 64'(lsu_gnt), 64'(i % 2 == 0));
            step();
        end

        // Ext write burst of 4 at 0x100 with LSU contending throughout
        drive(1, 0, 64'h20, 0, 0, 0, 0);
        step();
        for (int k = 0; k < 4; k++) begin
            drive(1, 0, 64'h28, 1, (k == 0) ? 1'b1 : 1'($urandom), (k == 0) ? 64'h100 : rand_addr(), 4'd3);
            #1;
            chk("t3_addr", mem_addr, 64'h100 + 64'(k * 8));
            chk("t3_busy", 64'(busy), 64'(k > 0));
            step();
        end
        drive(1, 0, 64'h28, 1, 0, 64'h30, 0);
        #1;
        chk("t3_lsu_after", 64'(lsu_gnt), 64'd1);
        step();

        // Read burst aborted after the first beat
        drive(0, 0, 0, 1, 0, 64'h200, 4'd2);
        step();
        drive(1, 0, 64'h38, 0, 0, 0, 0);
        #1;
        chk("t4_no_access", 64'(mem_ren | mem_wen), 64'd0);
        step();
        drive(1, 0, 64'h38, 0, 0, 0, 0);
        #1;
        chk("t4_lsu", 64'(lsu_gnt), 64'd1);
        step();

        // Burst address wrap
        drive(0, 0, 0, 1, 1, 64'hFFFF_FFFF_FFFF_FFF8, 4'd1);
        step();
        drive(0, 0, 0, 1, 1, 64'h500, 4'd1);
        #1;
        chk("t5_wrap", mem_addr, 64'h0);
        step();

        // Reset during beat 2 of a 4-beat read burst
        drive(0, 0, 0, 1, 0, 64'h300, 4'd3);
        step();
        drive(1, 0, 64'h50, 1, 0, 64'h300, 4'd3);
        #1;
        eval_check();
        #1;
        arst_n = 1'b0;
        #1;
        chk("t6_gnt", 64'({lsu_gnt, ext_gnt}), 64'd0);
        chk("t6_busy", 64'(busy), 64'd0);
        model_reset();
        @(negedge clk);
        #1;
        chk("t6_rvalid", 64'({lsu_rvalid, ext_rvalid}), 64'd0);
        chk("t6_busy2", 64'(busy), 64'd0);
        @(negedge clk);
        arst_n = 1'b1;
        drive(1, 0, 64'h58, 1, 0, 64'h60, 0);
        #1;
        chk("t6_lsu_wins", 64'(lsu_gnt), 64'd1);
        step();

        // Random traffic against the model
        for (int c = 0; c < 3000; c++) begin
            if (c == 1500) hard_reset();
            drive(($urandom_range(0, 2) != 0), 1'($urandom), rand_addr(),
                  ($urandom_range(0, 5) != 0), 1'($urandom), rand_addr(),
                  ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'($urandom_range(0, 1)));
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/dmem_arbiter.md
# dmem_arbiter

Shares one port of the 64-bit data-memory SRAM between the CPU load/store unit (LSU) and the external loader/DMA requester. Each cycle it issues at most one access, arbitrates round-robin between single-beat requests, and lets the external side hold the port for an auto-incrementing burst. It routes the one-cycle-late read data back to the requester that issued the read. It sits between the LSU/external interfaces and `sram_BW64` port 1.

## Interface
Parameters:
- `ADDR_W`, 64: byte-address width.
- `DATA_W`, 64: data width. The address stride is `DATA_W/8` bytes.
- `LEN_W`, 4: width of the burst length field.

Ports (clock and reset first; the clock is `clk`, and reset is `arst_n`, asynchronous, active-low):
- `clk`  in  1  system clock.
- `arst_n`  in  1  asynchronous active-low reset.
- `lsu_req`  in  1  LSU access request.
- `lsu_wen`  in  1  1 = write, 0 = read.
- `lsu_addr`  in  ADDR_W  LSU byte address.
- `lsu_wdata`  in  DATA_W  LSU write data.
- `lsu_gnt`  out  1  LSU request accepted this cycle.
- `lsu_rvalid`  out  1  LSU read data valid.
- `lsu_rdata`  out  DATA_W  LSU read data.
- `ext_req`  in  1  external access request.
- `ext_wen`  in  1  1 = write, 0 = read.
- `ext_addr`  in  ADDR_W  external start address.
- `ext_wdata`  in  DATA_W  external write data.
- `ext_len`  in  LEN_W  number of beats minus 1; sampled on the first beat only.
- `ext_gnt`  out  1  external beat accepted this cycle.
- `ext_rvalid`  out  1  external read data valid.
- `ext_rdata`  out  DATA_W  external read data.
- `mem_addr`  out  ADDR_W  SRAM address.
- `mem_wen`  out  1  SRAM write enable.
- `mem_ren`  out  1  SRAM read enable.
- `mem_wdata`  out  DATA_W  SRAM write data.
- `mem_rdata`  in  DATA_W  SRAM read data, valid one cycle after the read is issued.
- `busy`  out  1  an external burst is in progress.

## Operation
- An access is accepted in a cycle when `req && gnt` for that requester. `lsu_gnt` and `ext_gnt` are one-hot or zero.
- `mem_*` are driven combinationally from the winning requester in the same cycle; the SRAM samples them on the next rising edge of `clk`. With no winner, `mem_wen = mem_ren = 0`.
- The FSM has two states, IDLE and BURST.
- IDLE, only one requester active: that requester wins.
- IDLE, both active: the requester not recorded in the `last` flop wins. `last` updates on every grant. Its reset value is EXT, so the LSU wins the first contention.
- IDLE, ext accepted with `ext_len != 0`: go to BURST. Load `beat_cnt = ext_len`, `burst_addr = ext_addr + DATA_W/8`, and latch `burst_wen = ext_wen`.
- BURST: the LSU is never granted. `ext_gnt = ext_req`.
- BURST beat accepted: drive `mem_addr = burst_addr` and `mem_wen`/`mem_ren` from `burst_wen`; `ext_addr` and `ext_wen` are ignored. Then `burst_addr += DATA_W/8` and `beat_cnt -= 1`.
- BURST: when `beat_cnt` reaches 0 after an accepted beat, return to IDLE and set `last = EXT`.
- BURST, `ext_req` low: the burst aborts. Return to IDLE in the next cycle with no access issued that cycle.
- `busy = (state == BURST)`.
- Address arithmetic is modulo 2^ADDR_W and wraps silently.
- Read return: a registered `rd_owner` (valid, id) is set on each accepted read. The next cycle, the matching `*_rvalid` pulses for 1 cycle and `*_rdata = mem_rdata`. The non-owner's rdata holds 0.
- Writes produce no response.

## Timing
- Reset values: `lsu_rvalid = ext_rvalid = 0`, state IDLE, `last` = EXT, `beat_cnt = 0`, `burst_addr = 0`, `busy = 0`. The combinational outputs (`gnt`, `mem_*`) are 0 while `arst_n` is low.
- Read latency: `rvalid` arrives exactly 1 cycle after the grant. Back-to-back reads give back-to-back `rvalid`.
- Throughput: 1 access per cycle, with no bubbles at requester switches.
- An (N+1)-beat burst occupies N+1 consecutive cycles when `ext_req` stays high.
- Reset asserted mid-burst: the burst is dropped immediately and any pending `rvalid` is suppressed.
- Same-cycle write then read of the same address by different requesters: order follows the grant order, and the SRAM returns the written value.

## Structure
- Package `dmem_arb_pkg`: state enum (IDLE, BURST), requester id typedef (LSU = 0, EXT = 1), `STRIDE` constant.
- Optional sub-module `rr_arb2`: two-input round-robin picker holding the `last` flop. Everything else stays in one module, 150–250 lines.

## Test plan
- Reset, then an LSU read of 0x10 only: `lsu_gnt` in cycle 0, `mem_addr = 0x10`, `mem_ren = 1`; `lsu_rvalid = 1` in cycle 1 with `lsu_rdata = mem_rdata`.
- Both requesting continuously (single beats, `ext_len = 0`): grants alternate LSU, EXT, LSU, EXT…, starting with the LSU.
- Ext write burst with `ext_len = 3` at 0x100 and the LSU requesting throughout: `mem_addr` = 0x100, 0x108, 0x110, 0x118 on consecutive cycles. `busy` is high for beats 2–4, the LSU gets no grant, then the LSU is granted the next cycle.
- Ext read burst with `ext_len = 2` and `ext_req` dropped after beat 1: 1 read issued, 1 `ext_rvalid` pulse, return to IDLE, LSU granted the following cycle.
- Burst at 0xFFFF_FFFF_FFFF_FFF8 with `ext_len = 1`: the second beat address wraps to 0x0.
- `arst_n` pulsed low during beat 2 of a 4-beat read burst: no `rvalid` appears the next cycle, state is IDLE, `busy = 0`, and the LSU wins the next contention.
